// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared single-port data memory.
// Port 0 is the CPU load/store path, port 1 the loader/debug path.
module dm_arbiter #(
  parameter int LAT = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Req0,
  input  logic          Req1,
  input  logic          Wr0,
  input  logic          Wr1,
  input  logic [AW-1:0] Ad0,
  input  logic [AW-1:0] Ad1,
  input  logic [DW-1:0] WD0,
  input  logic [DW-1:0] WD1,
  input  logic [3:0]    BE0,
  input  logic [3:0]    BE1,
  output logic          Gnt0,
  output logic          Gnt1,
  output logic          Done0,
  output logic          Done1,
  output logic [DW-1:0] RD0,
  output logic [DW-1:0] RD1,
  output logic          MemEn,
  output logic [3:0]    MemWe,
  output logic [AW-1:0] MemAd,
  output logic [DW-1:0] MemWD,
  input  logic [DW-1:0] MemRD,
  output logic          Stall
);

  localparam int CW = $clog2(LAT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          mem_en_q, mem_en_d;
  logic [3:0]    mem_we_q, mem_we_d;
  logic [AW-1:0] mem_ad_q, mem_ad_d;
  logic [DW-1:0] mem_wd_q, mem_wd_d;
  logic [DW-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic          pick_s;
  logic          finish_s;
  logic          capture_s;

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    mem_en_d  = 1'b0;
    mem_we_d  = 4'b0000;
    mem_ad_d  = mem_ad_q;
    mem_wd_d  = mem_wd_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    finish_s  = 1'b0;
    capture_s = 1'b0;
    // On a tie the port that did not win last time goes first.
    pick_s    = (Req0 & Req1) ? ~last_q : Req1;

    case (state_q)
      IDLE: begin
        if (Req0 | Req1) begin
          owner_d  = pick_s;
          last_d   = pick_s;
          wr_d     = pick_s ? Wr1 : Wr0;
          mem_ad_d = pick_s ? Ad1 : Ad0;
          mem_wd_d = pick_s ? WD1 : WD0;
          mem_we_d = (pick_s ? Wr1 : Wr0) ? (pick_s ? BE1 : BE0) : 4'b0000;
          mem_en_d = 1'b1;
          gnt0_d   = ~pick_s;
          gnt1_d   = pick_s;
          state_d  = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          finish_s = 1'b1;
        end else if (LAT == 1) begin
          finish_s  = 1'b1;
          capture_s = 1'b1;
        end else begin
          cnt_d   = CW'(LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == CW'(0)) begin
          finish_s  = 1'b1;
          capture_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (finish_s) begin
      state_d = DONE;
      done0_d = ~owner_q;
      done1_d = owner_q;
    end else begin
      done0_d = 1'b0;
      done1_d = 1'b0;
    end

    if (capture_s && owner_q) begin
      rd1_d = MemRD;
    end else if (capture_s) begin
      rd0_d = MemRD;
    end else begin
      rd0_d = rd0_q;
      rd1_d = rd1_q;
    end
  end

  // State, operand and output registers; reset abandons any access in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 4'b0000;
      mem_ad_q <= '0;
      mem_wd_q <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_ad_q <= mem_ad_d;
      mem_wd_q <= mem_wd_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

  assign Gnt0  = gnt0_q;
  assign Gnt1  = gnt1_q;
  assign Done0 = done0_q;
  assign Done1 = done1_q;
  assign RD0   = rd0_q;
  assign RD1   = rd1_q;
  assign MemEn = mem_en_q;
  assign MemWe = mem_we_q;
  assign MemAd = mem_ad_q;
  assign MemWD = mem_wd_q;
  // Released in the Done0 cycle so the PC moves on the edge that ends it.
  assign Stall = Req0 & ~done0_q;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer for the shared single-port data memory. Port 0 is the CPU load/store path (address from the ALU, write data from BusB). Port 1 is the loader/debug port that preloads or inspects memory. The block serialises accesses with round-robin fairness and runs the memory's fixed read latency. It raises a stall to hold the PC while a CPU access is outstanding.

## Interface
Parameters:
- `LAT`, default 2: memory read latency in cycles from the issue edge to valid `MemRD`. Legal range is 1..4.
- `AW`, default 32: address width.
- `DW`, default 32: data width.

Ports:
- `Clk`, in, 1: single clock, rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Req0`, `Req1`, in, 1: request, level-held until the matching Done.
- `Wr0`, `Wr1`, in, 1: 1 = write, 0 = read.
- `Ad0`, `Ad1`, in, AW: address, passed unchanged.
- `WD0`, `WD1`, in, DW: write data.
- `BE0`, `BE1`, in, 4: byte enables for writes.
- `Gnt0`, `Gnt1`, out, 1: high while that port owns the memory (ISSUE through DONE).
- `Done0`, `Done1`, out, 1: one-cycle completion pulse.
- `RD0`, `RD1`, out, DW: read data, registered, held until that port's next read completes.
- `MemEn`, out, 1: memory access strobe.
- `MemWe`, out, 4: byte write enables, 0 on reads.
- `MemAd`, out, AW: memory address.
- `MemWD`, out, DW: memory write data.
- `MemRD`, in, DW: memory read data, valid LAT cycles after the issue edge.
- `Stall`, out, 1: combinational `Req0 & ~Done0`. It freezes the PC and the instruction register.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any Req is high, select the owner, latch its Wr/Ad/WD/BE, and go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - If exactly one Req is high, that port wins.
  - If both are high, the port not granted last wins.
  - The last-grant pointer updates on each grant. Reset sets last = 1, so port 0 wins the first tie.
- ISSUE lasts one cycle:
  - `MemEn=1`. `MemAd`, `MemWD` and `MemWe` come from the latched operands (`MemWe = BE` if write, else 0).
  - Write: go to DONE.
  - Read: load the counter with LAT−1. If LAT = 1, go straight to DONE with a capture. Otherwise go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture `MemRD` into the owner's RD register and go to DONE.
- DONE lasts one cycle:
  - Pulse the owner's Done.
  - Return to IDLE.
- Outside ISSUE, `MemEn=0` and `MemWe=0`. `MemAd` and `MemWD` hold their last values.
- Dropping Req mid-transaction does not abort it. The access completes and Done still pulses.
- A requester must deassert Req, or change its operands for a new access, at the edge ending its Done cycle. A Req still high in the following IDLE cycle is treated as a new request.
- The counter is sized ceil(log2(LAT))+1 bits and never wraps. LAT outside 1..4 is illegal and is not checked in RTL.
- Reset, asynchronous and valid at any point including mid-access:
  - State goes to IDLE and the last-grant pointer to 1.
  - `Gnt*`, `Done*`, `MemEn` and `MemWe` go to 0.
  - `MemAd`, `MemWD`, `RD0` and `RD1` go to 0.
  - An interrupted access is lost, with no Done.

## Timing
- Request seen in IDLE during cycle t:
  - ISSUE in cycle t+1.
  - Write: Done in cycle t+2.
  - Read: Done in cycle t+1+LAT, with RD valid from that cycle.
- Gnt is high from cycle t+1 through the Done cycle inclusive.
- Minimum spacing between issues is 3 cycles for writes and LAT+2 cycles for reads.
- Worst-case wait for a port under continuous contention is one full transaction of the other port plus one IDLE cycle.
- Stall is combinational with no register. Its deassertion coincides with the Done0 cycle, so the PC advances at the edge ending that cycle.

## Test plan
1. Port-0 read, LAT=2, `Ad0=0x10`, memory returns `0xDEADBEEF`, Req0 high in cycle 0:
   - `MemEn` high in cycle 1 only.
   - `Done0` and `RD0=0xDEADBEEF` in cycle 3.
   - `Stall` high in cycles 0–2 and low in cycle 3.
2. Port-1 write, `Ad1=0x20`, `WD1=0x12345678`, `BE1=4'b0011`:
   - In cycle 1: `MemEn=1`, `MemWe=4'b0011`, `MemAd=0x20`, `MemWD=0x12345678`.
   - `Done1` in cycle 2.
   - `Gnt0` stays 0 throughout.
3. Both ports request reads from reset and hold Req across 4 transactions:
   - Grant order is 0, 1, 0, 1.
   - Each Done pulses exactly once per transaction.
   - Gnt0 and Gnt1 are never high together.
4. Port 0 issues back-to-back writes, keeping Req0 high with new operands after each Done:
   - Issues land in cycles 1, 4 and 7.
   - Port 1 idle throughout.
5. Reset asserted during WAIT of a LAT=4 read:
   - Outputs go to 0 immediately, with no Done.
   - After release, a port-1/port-0 tie grants port 0.
6. Req1 dropped in the cycle after ISSUE of a read:
   - The access completes.
   - `Done1` pulses and `RD1` updates.
   - The FSM returns to IDLE, with no second access.
